// File: rtl/data_mem_responder_pkg.sv
// Shared types and helpers for the data memory responder and its bus interface.
// Lane [0] of a word is always the most significant byte (big-endian).
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef logic [7:0] byte_t;
  typedef byte_t [0:3] word_lanes_t;

  localparam logic [31:0] ERR_WORD_DEFAULT = 32'hDEADBEEF;

  function automatic logic [31:0] pack_lanes(input word_lanes_t lanes);
    return {lanes[0], lanes[1], lanes[2], lanes[3]};
  endfunction

  function automatic word_lanes_t unpack_lanes(input logic [31:0] word);
    word_lanes_t lanes;
    lanes[0] = word[31:24];
    lanes[1] = word[23:16];
    lanes[2] = word[15:8];
    lanes[3] = word[7:0];
    return lanes;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Core data-port bus: request side is the core (master), memory is the slave.
interface data_mem_responder_if;
  import mem_pkg::*;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_write_en;
  word_lanes_t mem_data_in;
  logic        halted;
  word_lanes_t mem_data_out;
  logic        mem_ready;
  logic        mem_err;

  modport master (
    output mem_req, mem_addr, mem_write_en, mem_data_in, halted,
    input  mem_data_out, mem_ready, mem_err
  );

  modport slave (
    input  mem_req, mem_addr, mem_write_en, mem_data_in, halted,
    output mem_data_out, mem_ready, mem_err
  );

endinterface

// File: rtl/data_mem_responder_word_ram.sv
// Word-wide storage: synchronous write, combinational read, no reset.
module word_ram #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned AW        = 10
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [0:MEM_WORDS-1];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_mem_responder.sv
// Data-port responder: request/ready handshake with programmable latency,
// big-endian word storage, sticky error on misaligned or out-of-range access.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned LATENCY   = 2,
  parameter logic [31:0] ERR_WORD  = ERR_WORD_DEFAULT
) (
  input logic                 clk,
  input logic                 rst_b,
  data_mem_responder_if.slave bus
);

  localparam int unsigned AW       = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [3:0]  CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  word_lanes_t dout_q, dout_d;
  logic        err_q, err_d;

  logic        accept;
  logic        complete;
  logic        acc_err;
  logic        acc_we;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [31:0] ram_rdata;
  logic        ram_we;

  assign accept = bus.mem_req && !bus.halted && (state_q == IDLE || state_q == RESP);

  // A single-cycle access completes on its accepting edge, so it must see the live bus.
  assign acc_addr  = (state_q == WAIT) ? addr_q  : bus.mem_addr;
  assign acc_we    = (state_q == WAIT) ? we_q    : bus.mem_write_en;
  assign acc_wdata = (state_q == WAIT) ? wdata_q : pack_lanes(bus.mem_data_in);

  assign acc_err = (acc_addr[1:0] != 2'b00) || ({2'b00, acc_addr[31:2]} >= 32'(MEM_WORDS));
  assign ram_we  = complete && acc_we && !acc_err && rst_b;

  word_ram #(
    .MEM_WORDS (MEM_WORDS),
    .AW        (AW)
  ) u_word_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (acc_addr[AW+1:2]),
    .wdata_i (acc_wdata),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    dout_d   = dout_q;
    err_d    = err_q;
    complete = 1'b0;

    case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (accept) begin
          addr_d  = bus.mem_addr;
          we_d    = bus.mem_write_en;
          wdata_d = pack_lanes(bus.mem_data_in);
          if (LATENCY == 1) begin
            state_d  = RESP;
            complete = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d  = RESP;
          complete = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (complete) begin
      if (acc_err) begin
        dout_d = unpack_lanes(ERR_WORD);
        err_d  = 1'b1;
      end else if (acc_we) begin
        dout_d = unpack_lanes(acc_wdata);
      end else begin
        dout_d = unpack_lanes(ram_rdata);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      we_q    <= 1'b0;
      wdata_q <= 32'd0;
      dout_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
    end
  end

  assign bus.mem_ready    = (state_q == RESP);
  assign bus.mem_data_out = dout_q;
  assign bus.mem_err      = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: three responders (LATENCY 2, 1, 4) driven independently and
// compared against a word-array reference model with sticky error tracking.
module tb_data_mem_responder;
  import mem_pkg::*;

  localparam int unsigned MW   = 1024;
  localparam int          ND   = 3;
  localparam logic [31:0] ERRW = 32'hDEADBEEF;

  logic clk   = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  logic        req_s  [ND];
  logic [31:0] addr_s [ND];
  logic        we_s   [ND];
  word_lanes_t din_s  [ND];
  logic        halt_s [ND];
  wire              rdy_w  [ND];
  wire word_lanes_t dout_w [ND];
  wire              err_w  [ND];

  generate
    for (genvar gi = 0; gi < ND; gi++) begin : g_dut
      data_mem_responder_if bus ();
      assign bus.mem_req      = req_s[gi];
      assign bus.mem_addr     = addr_s[gi];
      assign bus.mem_write_en = we_s[gi];
      assign bus.mem_data_in  = din_s[gi];
      assign bus.halted       = halt_s[gi];
      assign rdy_w[gi]        = bus.mem_ready;
      assign dout_w[gi]       = bus.mem_data_out;
      assign err_w[gi]        = bus.mem_err;
      data_mem_responder #(
        .MEM_WORDS (MW),
        .LATENCY   ((gi == 0) ? 2 : ((gi == 1) ? 1 : 4)),
        .ERR_WORD  (ERRW)
      ) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus.slave)
      );
    end
  endgenerate

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] mdl [int];
  bit          err_exp [ND];

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 4);
  endfunction

  function automatic int key_of(input int d, input logic [31:0] addr);
    return d * 65536 + int'(addr / 32'd4);
  endfunction

  // Reference: byte address space 0..4*MW-1, word aligned, no wrap.
  function automatic logic [31:0] model_access(input int d, input bit we, input logic [31:0] addr,
                                               input logic [31:0] wdata, output bit known);
    known = 1'b1;
    if ((addr % 32'd4) != 32'd0 || addr >= 32'(4 * MW)) begin
      err_exp[d] = 1'b1;
      return ERRW;
    end
    if (we) begin
      mdl[key_of(d, addr)] = wdata;
      return wdata;
    end
    if (!mdl.exists(key_of(d, addr))) begin
      known = 1'b0;
      return 32'd0;
    end
    return mdl[key_of(d, addr)];
  endfunction

  // Drives one request for a single cycle, then scrambles the inputs and observes 20 cycles.
  task automatic xfer(input int d, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                      output int rdy_at, output int rdy_cnt, output logic [31:0] data,
                      output logic [31:0] held, output logic err_at);
    req_s[d] = 1'b1; we_s[d] = we; addr_s[d] = addr; din_s[d] = wdata;
    rdy_at = -1; rdy_cnt = 0; data = 32'd0; held = 32'd0; err_at = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req_s[d] = 1'b0; we_s[d] = 1'($urandom); addr_s[d] = $urandom; din_s[d] = $urandom;
      end
      if (rdy_at >= 0 && c == rdy_at + 1) held = dout_w[d];
      if (rdy_w[d] === 1'b1) begin
        rdy_cnt++;
        if (rdy_at < 0) begin
          rdy_at = c; data = dout_w[d]; err_at = err_w[d];
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] w;
    rst_b = 1'b0;
    for (int d = 0; d < ND; d++) begin
      req_s[d] = 1'b1; addr_s[d] = 32'h0; we_s[d] = 1'b1; din_s[d] = 32'h12345678; halt_s[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      w = dout_w[d];
      n_checks++; if (rdy_w[d] !== 1'b0) $display("FAIL reset_ready d=%0d got=%b exp=0", d, rdy_w[d]); else n_pass++;
      n_checks++; if (w !== 32'h0) $display("FAIL reset_data d=%0d got=%h exp=00000000", d, w); else n_pass++;
      n_checks++; if (err_w[d] !== 1'b0) $display("FAIL reset_err d=%0d got=%b exp=0", d, err_w[d]); else n_pass++;
      req_s[d] = 1'b0;
      err_exp[d] = 1'b0;
    end
    rst_b = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      n_checks++; if (rdy_w[d] !== 1'b0) $display("FAIL idle_ready d=%0d got=%b exp=0", d, rdy_w[d]); else n_pass++;
    end
  endtask

  task automatic test_store_load();
    int ra, rc; logic [31:0] data, held, exp; logic ea; bit known;
    for (int d = 0; d < ND; d++) begin
      exp = model_access(d, 1'b1, 32'h10, 32'h11223344, known);
      xfer(d, 1'b1, 32'h10, 32'h11223344, ra, rc, data, held, ea);
      $display("store d=%0d addr=10 ready_cycle=%0d echo=%h", d, ra, data);
      n_checks++; if (ra != lat_of(d)) $display("FAIL store_latency d=%0d got=%0d exp=%0d", d, ra, lat_of(d)); else n_pass++;
      n_checks++; if (rc != 1) $display("FAIL store_pulses d=%0d got=%0d exp=1", d, rc); else n_pass++;
      n_checks++; if (data !== exp) $display("FAIL store_echo d=%0d got=%h exp=%h", d, data, exp); else n_pass++;
      n_checks++; if (dout_w[d][0] !== 8'h11 || dout_w[d][3] !== 8'h44) $display("FAIL lane_order d=%0d got=%h exp=11223344", d, dout_w[d]); else n_pass++;
      exp = model_access(d, 1'b0, 32'h10, 32'h0, known);
      xfer(d, 1'b0, 32'h10, 32'h0, ra, rc, data, held, ea);
      $display("load  d=%0d addr=10 ready_cycle=%0d data=%h", d, ra, data);
      n_checks++; if (data !== exp) $display("FAIL load_data d=%0d got=%h exp=%h", d, data, exp); else n_pass++;
      n_checks++; if (held !== exp) $display("FAIL data_hold d=%0d got=%h exp=%h", d, held, exp); else n_pass++;
      n_checks++; if (ea !== 1'b0) $display("FAIL load_err d=%0d got=%b exp=0", d, ea); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int first, second, cnt, l; logic [31:0] d1, d2, e1, e2; bit known;
    for (int d = 0; d < ND; d++) begin
      l = lat_of(d);
      e1 = model_access(d, 1'b1, 32'h20, 32'hCAFEF00D, known);
      e2 = model_access(d, 1'b0, 32'h20, 32'h0, known);
      req_s[d] = 1'b1; we_s[d] = 1'b1; addr_s[d] = 32'h20; din_s[d] = 32'hCAFEF00D;
      first = -1; second = -1; cnt = 0; d1 = 32'd0; d2 = 32'd0;
      for (int c = 1; c <= 2 * l + 4; c++) begin
        @(negedge clk);
        if (c == 1) req_s[d] = 1'b0;
        if (rdy_w[d] === 1'b1) begin
          cnt++;
          if (first < 0) begin first = c; d1 = dout_w[d]; end
          else if (second < 0) begin second = c; d2 = dout_w[d]; end
        end
        if (c == l) begin req_s[d] = 1'b1; we_s[d] = 1'b0; addr_s[d] = 32'h20; end
        if (c == l + 1) req_s[d] = 1'b0;
      end
      $display("b2b   d=%0d ready_cycles=%0d,%0d data=%h,%h", d, first, second, d1, d2);
      n_checks++; if (first != l || second != 2 * l) $display("FAIL b2b_timing d=%0d got=%0d,%0d exp=%0d,%0d", d, first, second, l, 2 * l); else n_pass++;
      n_checks++; if (cnt != 2) $display("FAIL b2b_pulses d=%0d got=%0d exp=2", d, cnt); else n_pass++;
      n_checks++; if (d1 !== e1 || d2 !== e2) $display("FAIL b2b_data d=%0d got=%h,%h exp=%h,%h", d, d1, d2, e1, e2); else n_pass++;
    end
  endtask

  task automatic test_halted();
    int cnt, ra; logic [31:0] addr, wd, exp, data; bit known;
    for (int d = 0; d < ND; d++) begin
      halt_s[d] = 1'b1; req_s[d] = 1'b1; we_s[d] = 1'b0; addr_s[d] = 32'h10;
      cnt = 0;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        if (rdy_w[d] === 1'b1) cnt++;
      end
      req_s[d] = 1'b0; halt_s[d] = 1'b0;
      @(negedge clk);
      if (rdy_w[d] === 1'b1) cnt++;
      $display("halt  d=%0d ready_pulses_while_halted=%0d", d, cnt);
      n_checks++; if (cnt != 0) $display("FAIL halted_blocks d=%0d got=%0d exp=0", d, cnt); else n_pass++;
      addr = 32'h80 + 32'(4 * d); wd = $urandom;
      exp = model_access(d, 1'b1, addr, wd, known);
      req_s[d] = 1'b1; we_s[d] = 1'b1; addr_s[d] = addr; din_s[d] = wd;
      ra = -1; data = 32'd0;
      for (int c = 1; c <= 20; c++) begin
        @(negedge clk);
        if (c == 1) begin req_s[d] = 1'b0; halt_s[d] = 1'b1; end
        if (rdy_w[d] === 1'b1 && ra < 0) begin ra = c; data = dout_w[d]; end
      end
      halt_s[d] = 1'b0;
      $display("halt  d=%0d inflight ready_cycle=%0d echo=%h", d, ra, data);
      n_checks++; if (ra != lat_of(d)) $display("FAIL halted_inflight d=%0d got=%0d exp=%0d", d, ra, lat_of(d)); else n_pass++;
      n_checks++; if (data !== exp) $display("FAIL halted_echo d=%0d got=%h exp=%h", d, data, exp); else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int d = 0; d < ND; d++) begin
      for (int i = 0; i < 25; i++) begin
        bit we, known; logic [31:0] addr, wd, exp, data, held; int ra, rc; logic ea;
        we = 1'($urandom); addr = 32'($urandom_range(0, 31)) * 32'd4; wd = $urandom;
        if (!we && !mdl.exists(key_of(d, addr))) we = 1'b1;
        exp = model_access(d, we, addr, wd, known);
        xfer(d, we, addr, wd, ra, rc, data, held, ea);
        $display("rand  d=%0d we=%0d addr=%h ready_cycle=%0d data=%h exp=%h", d, we, addr, ra, data, exp);
        n_checks++; if (ra != lat_of(d) || rc != 1) $display("FAIL rand_timing d=%0d got=%0d/%0d exp=%0d/1", d, ra, rc, lat_of(d)); else n_pass++;
        n_checks++; if (known && data !== exp) $display("FAIL rand_data d=%0d got=%h exp=%h", d, data, exp); else n_pass++;
        n_checks++; if (ea !== err_exp[d]) $display("FAIL rand_err d=%0d got=%b exp=%b", d, ea, err_exp[d]); else n_pass++;
      end
    end
  endtask

  task automatic test_errors();
    int ra, rc; logic [31:0] data, held, exp, v0, v1; logic ea; bit known;
    for (int d = 0; d < ND; d++) begin
      v0 = $urandom; v1 = $urandom;
      exp = model_access(d, 1'b1, 32'h0, v0, known);
      xfer(d, 1'b1, 32'h0, v0, ra, rc, data, held, ea);
      exp = model_access(d, 1'b1, 32'hFFC, v1, known);
      xfer(d, 1'b1, 32'hFFC, v1, ra, rc, data, held, ea);
      n_checks++; if (ea !== 1'b0 || data !== exp) $display("FAIL last_word_store d=%0d got=%h/%b exp=%h/0", d, data, ea, exp); else n_pass++;
      exp = model_access(d, 1'b0, 32'h13, 32'h0, known);
      xfer(d, 1'b0, 32'h13, 32'h0, ra, rc, data, held, ea);
      $display("err   d=%0d misaligned addr=13 ready_cycle=%0d data=%h err=%b", d, ra, data, ea);
      n_checks++; if (ra != lat_of(d)) $display("FAIL misalign_latency d=%0d got=%0d exp=%0d", d, ra, lat_of(d)); else n_pass++;
      n_checks++; if (data !== exp) $display("FAIL misalign_data d=%0d got=%h exp=%h", d, data, exp); else n_pass++;
      n_checks++; if (ea !== 1'b1) $display("FAIL misalign_err d=%0d got=%b exp=1", d, ea); else n_pass++;
      exp = model_access(d, 1'b1, 32'h1000, 32'h55AA55AA, known);
      xfer(d, 1'b1, 32'h1000, 32'h55AA55AA, ra, rc, data, held, ea);
      $display("err   d=%0d out_of_range addr=1000 data=%h err=%b", d, data, ea);
      n_checks++; if (data !== exp) $display("FAIL oor_data d=%0d got=%h exp=%h", d, data, exp); else n_pass++;
      exp = model_access(d, 1'b1, 32'hFFFFFFFC, 32'h66666666, known);
      xfer(d, 1'b1, 32'hFFFFFFFC, 32'h66666666, ra, rc, data, held, ea);
      exp = model_access(d, 1'b0, 32'h0, 32'h0, known);
      xfer(d, 1'b0, 32'h0, 32'h0, ra, rc, data, held, ea);
      $display("err   d=%0d reload addr=0 data=%h exp=%h err=%b", d, data, exp, ea);
      n_checks++; if (data !== exp) $display("FAIL no_alias_word0 d=%0d got=%h exp=%h", d, data, exp); else n_pass++;
      n_checks++; if (ea !== err_exp[d]) $display("FAIL err_sticky d=%0d got=%b exp=%b", d, ea, err_exp[d]); else n_pass++;
      exp = model_access(d, 1'b0, 32'hFFC, 32'h0, known);
      xfer(d, 1'b0, 32'hFFC, 32'h0, ra, rc, data, held, ea);
      n_checks++; if (data !== exp) $display("FAIL no_alias_last d=%0d got=%h exp=%h", d, data, exp); else n_pass++;
      n_checks++; if (err_w[d] !== 1'b1) $display("FAIL err_hold d=%0d got=%b exp=1", d, err_w[d]); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int ra, rc; logic [31:0] data, held, exp, old, w; logic ea; bit known;
    for (int d = 0; d < ND; d += 2) begin
      old = $urandom | 32'h100;
      exp = model_access(d, 1'b1, 32'h40, old, known);
      xfer(d, 1'b1, 32'h40, old, ra, rc, data, held, ea);
      req_s[d] = 1'b1; we_s[d] = 1'b1; addr_s[d] = 32'h40; din_s[d] = 32'h55;
      @(negedge clk);
      req_s[d] = 1'b0;
      #1 rst_b = 1'b0;
      #1;
      w = dout_w[d];
      $display("rstm  d=%0d ready=%b data=%h err=%b", d, rdy_w[d], w, err_w[d]);
      n_checks++; if (rdy_w[d] !== 1'b0) $display("FAIL rstmid_ready d=%0d got=%b exp=0", d, rdy_w[d]); else n_pass++;
      n_checks++; if (w !== 32'h0) $display("FAIL rstmid_data d=%0d got=%h exp=00000000", d, w); else n_pass++;
      n_checks++; if (err_w[d] !== 1'b0) $display("FAIL rstmid_err d=%0d got=%b exp=0", d, err_w[d]); else n_pass++;
      for (int k = 0; k < ND; k++) err_exp[k] = 1'b0;
      @(negedge clk);
      rst_b = 1'b1;
      @(negedge clk);
      exp = model_access(d, 1'b0, 32'h40, 32'h0, known);
      xfer(d, 1'b0, 32'h40, 32'h0, ra, rc, data, held, ea);
      $display("rstm  d=%0d reload addr=40 data=%h exp=%h", d, data, exp);
      n_checks++; if (data !== exp) $display("FAIL rstmid_no_commit d=%0d got=%h exp=%h", d, data, exp); else n_pass++;
      n_checks++; if (ra != lat_of(d) || ea !== 1'b0) $display("FAIL rstmid_after d=%0d got=%0d/%b exp=%0d/0", d, ra, ea, lat_of(d)); else n_pass++;
    end
  endtask

  initial begin
    for (int d = 0; d < ND; d++) begin
      req_s[d] = 1'b0; addr_s[d] = 32'h0; we_s[d] = 1'b0; din_s[d] = '0; halt_s[d] = 1'b0; err_exp[d] = 1'b0;
    end
    test_reset();
    test_store_load();
    test_back_to_back();
    test_halted();
    test_random();
    test_errors();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached, passed=%0d total=%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
